// File: rtl/pulse_pacer.sv
// pulse_pacer: counts incoming single-cycle event pulses and re-emits them paced
// at least GAP_CYCLES idle cycles apart, so a downstream synchroniser never loses one.
// Latency: 1 cycle on the idle fast path; otherwise events wait in the pending counter.
// Backpressure: none upstream. When the backlog is full, a new event is dropped and
// flagged on out_overflow for one cycle.
// Optional: define PULSE_PACER_DROP_CNT_EN to add the saturating out_drop_cnt port.
// GAP_CYCLES must lie in 1..2**GAP_WIDTH-1.

module pulse_pacer #(
    parameter int CNT_WIDTH  = 4,
    parameter int GAP_CYCLES = 8,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 in_pulse,
    output logic                 out_pulse,
    output logic [CNT_WIDTH-1:0] out_pending,
    output logic                 out_full,
`ifdef PULSE_PACER_DROP_CNT_EN
    output logic                 out_overflow,
    output logic [CNT_WIDTH-1:0] out_drop_cnt
`else
    output logic                 out_overflow
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(GAP_CYCLES);

    state_t               state_q;
    logic [GAP_WIDTH-1:0] timer_q;
    logic                 pulse_q;
    logic [CNT_WIDTH-1:0] pending_q;
    logic [CNT_WIDTH-1:0] pending_d;
    logic                 overflow_q;
    logic                 emit;
    logic                 accept;
    logic                 drop;

    assign out_full     = (pending_q == CNT_MAX);
    assign out_pulse    = pulse_q;
    assign out_pending  = pending_q;
    assign out_overflow = overflow_q;

    // Emit/accept/drop decisions and the next pending count.
    // An accept and an emit in the same cycle cancel out. Because of that, the counter
    // can neither wrap at full nor underflow at zero.
    always_comb begin
        emit      = (state_q == IDLE) && ((pending_q != '0) || in_pulse);
        accept    = in_pulse && (!out_full || emit);
        drop      = in_pulse && out_full && !emit;
        pending_d = pending_q;
        if (accept && !emit) begin
            pending_d = pending_q + CNT_WIDTH'(1);
        end else if (emit && !accept) begin
            pending_d = pending_q - CNT_WIDTH'(1);
        end
    end

    // Pacing FSM.
    // One emit is followed by GAP_CYCLES cycles in GAP, and out_pulse is registered.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (emit) begin
                        pulse_q <= 1'b1;
                        timer_q <= GAP_LOAD;
                        state_q <= GAP;
                    end else begin
                        pulse_q <= 1'b0;
                    end
                end
                GAP: begin
                    pulse_q <= 1'b0;
                    timer_q <= timer_q - GAP_WIDTH'(1);
                    if (timer_q == GAP_WIDTH'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    pulse_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pending-event counter and the one-cycle overflow flag.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= drop;
        end
    end

`ifdef PULSE_PACER_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    assign out_drop_cnt = drop_cnt_q;

    // Saturating count of dropped events. Only reset clears it.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pulse_pacer.sv
// Testbench for pulse_pacer: directed scenarios followed by random traffic.
// A timing-level model produces the expected outputs. A monitor on the falling edge
// pops those expectations from the scoreboard queues and compares them with the DUT.
module tb_pulse_pacer;

    localparam int CNT_W = 4;
    localparam int GAP   = 8;
    localparam int GAP_W = 8;
    localparam int MAXP  = (1 << CNT_W) - 1;

    typedef struct {
        int cyc;
        bit rst;
        bit pulse;
        int pend;
        bit full;
        bit ovf;
        int drop;
    } exp_t;

    logic             clk = 1'b0;
    logic             in_reset = 1'b1;
    logic             in_pulse = 1'b0;
    logic             out_pulse;
    logic [CNT_W-1:0] out_pending;
    logic             out_full;
    logic             out_overflow;
`ifdef PULSE_PACER_DROP_CNT_EN
    logic [CNT_W-1:0] out_drop_cnt;
`endif

    pulse_pacer #(
        .CNT_WIDTH (CNT_W),
        .GAP_CYCLES(GAP),
        .GAP_WIDTH (GAP_W)
    ) dut (
        .in_clk      (clk),
        .in_reset    (in_reset),
        .in_pulse    (in_pulse),
        .out_pulse   (out_pulse),
        .out_pending (out_pending),
        .out_full    (out_full),
`ifdef PULSE_PACER_DROP_CNT_EN
        .out_overflow(out_overflow),
        .out_drop_cnt(out_drop_cnt)
`else
        .out_overflow(out_overflow)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   pulse_q[$];

    // Reference model state: pending backlog, edge of the last emit decision, dropped events.
    int m_pend = 0;
    int m_last = 0;
    bit m_have_last = 0;
    int m_drop = 0;
    int req_cnt = 0;

    // Monitor-side tallies, kept since the most recent reset.
    int  mon_pulses = 0;
    int  mon_ovf = 0;
    bit  prev_pulse = 0;
    bit  have_rise = 0;
    int  last_rise = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    // Drive one cycle of stimulus and push the model's expectation for the next edge.
    task automatic step(input bit p, input bit r);
        exp_t e;
        int   tag;
        bit   can, emit, acc, drp;
        @(posedge clk);
        #1;
        in_pulse = p;
        in_reset = r;
        tag = cyc + 1;
        e.cyc = tag;
        e.rst = r;
        if (r) begin
            m_pend = 0;
            m_have_last = 0;
            m_drop = 0;
            req_cnt = 0;
            emit = 0;
            drp = 0;
        end else begin
            // Emission is allowed once GAP+1 edges have passed since the previous emit decision.
            can  = !m_have_last || (tag - m_last >= GAP + 1);
            emit = can && (m_pend > 0 || p);
            acc  = p && (m_pend < MAXP || emit);
            drp  = p && !acc;
            m_pend = m_pend + (acc ? 1 : 0) - (emit ? 1 : 0);
            if (p) req_cnt++;
            if (drp && m_drop < MAXP) m_drop++;
            if (emit) begin
                m_last = tag;
                m_have_last = 1;
                pulse_q.push_back(tag);
            end
        end
        e.pulse = emit;
        e.pend  = m_pend;
        e.full  = (m_pend == MAXP);
        e.ovf   = drp;
        e.drop  = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    // Monitor: compare the DUT outputs with the scoreboard entry for the edge just taken.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("pulse", {31'd0, out_pulse}, {31'd0, e.pulse});
            chk("pending", {{(32-CNT_W){1'b0}}, out_pending}, e.pend);
            chk("full", {31'd0, out_full}, {31'd0, e.full});
            chk("overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
`ifdef PULSE_PACER_DROP_CNT_EN
            chk("drop_cnt", {{(32-CNT_W){1'b0}}, out_drop_cnt}, e.drop);
`endif
            if (e.rst) begin
                mon_pulses = 0;
                mon_ovf = 0;
                have_rise = 0;
                prev_pulse = 0;
            end else begin
                if (out_pulse === 1'b1) begin
                    mon_pulses++;
                    chk("pulse_adjacent", {31'd0, prev_pulse}, 32'd0);
                    if (have_rise)
                        chk("pulse_spacing_ok", (cyc - last_rise >= GAP + 1) ? 32'd1 : 32'd0, 32'd1);
                    if (pulse_q.size() == 0) begin
                        chk("pulse_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("pulse_cycle", cyc, pulse_q.pop_front());
                    end
                    have_rise = 1;
                    last_rise = cyc;
                end
                if (out_overflow === 1'b1) mon_ovf++;
                prev_pulse = (out_pulse === 1'b1);
            end
        end
    end

    initial begin
        // Reset state.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // Single event takes the fast path.
        idle(9);
        burst(1);
        idle(20);
        // Seven-event burst is paced GAP+1 apart.
        burst(7);
        idle(80);
        // Backlog of two, with a new event on the exact cycle of an emit decision.
        burst(3);
        idle(6);
        burst(1);
        idle(40);
        // Overflow: a long burst saturates the backlog and drops events.
        burst(40);
        idle(5);
        // Reset in the middle of a backlog discards it; no pulses afterwards.
        step(1'b0, 1'b1);
        idle(50);
        // Random traffic with varying density and rare resets.
        for (int blk = 0; blk < 12; blk++) begin
            int rate;
            rate = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                step(($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
            end
        end
        // Drain the backlog.
        idle((MAXP + 2) * (GAP + 1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("pulse_q_drained", pulse_q.size(), 32'd0);
        chk("final_pending", {{(32-CNT_W){1'b0}}, out_pending}, 32'd0);
        chk("conservation", mon_pulses + mon_ovf + int'(out_pending), req_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
